// File: rtl/door_motion_sequencer_if.sv
// Sensor/limit-switch inputs and motor/status outputs of the door sequencer.
// master: sensor side that drives the inputs and observes the outputs.
// slave: the sequencer itself.
interface door_motion_sequencer_if;
  logic       sense;
  logic       obs;
  logic       lim_open;
  logic       lim_closed;
  logic       fault_clr;
  logic [1:0] motor;
  logic       alarm;
  logic       busy;
  logic [2:0] state;
  logic       tick_led;

  modport master (
    output sense, obs, lim_open, lim_closed, fault_clr,
    input  motor, alarm, busy, state, tick_led
  );

  modport slave (
    input  sense, obs, lim_open, lim_closed, fault_clr,
    output motor, alarm, busy, state, tick_led
  );
endinterface

// File: rtl/door_motion_sequencer.sv
// Automatic-door motor sequencer: limit-switch driven open/close, timed hold-open, obstacle retry limit with FAULT latch.
// Latency: input edge to output change is 3 clk (2-flop synchroniser + state register); rst clears outputs asynchronously.
// No backpressure: sensors are sampled every clk; optional motion watchdog enabled by defining DOOR_WATCHDOG_EN.
module door_motion_sequencer #(
  parameter int TICK_DIV       = 50000000,
  parameter int HOLD_TICKS     = 5,
  parameter int MAX_RETRIES    = 3,
  parameter int MOTION_TIMEOUT = 8
) (
  input logic                    clk,
  input logic                    rst,
  door_motion_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_CLOSED  = 3'd0,
    S_OPENING = 3'd1,
    S_OPEN    = 3'd2,
    S_CLOSING = 3'd3,
    S_FAULT   = 3'd4
  } state_t;

  localparam int TW = $clog2(TICK_DIV);
  localparam int HW = $clog2(HOLD_TICKS + 2);
  localparam int RW = $clog2(MAX_RETRIES + 2);

  // A tick divider below 2 would leave the tick permanently high; a zero timeout would fault instantly.
  if (TICK_DIV < 2 || MOTION_TIMEOUT < 1) begin : g_bad_cfg
    $error("door_motion_sequencer: TICK_DIV must be >= 2 and MOTION_TIMEOUT >= 1");
  end

  logic [4:0]    sync1;
  logic [4:0]    sync2;
  logic          s_sense;
  logic          s_obs;
  logic          s_lim_open;
  logic          s_lim_closed;
  logic          s_fault_clr;

  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic          tick_led;

  state_t        cur;
  state_t        nxt;
  logic [HW-1:0] hold_cnt;
  logic [HW-1:0] hold_nx;
  logic [RW-1:0] retry_cnt;
  logic [RW-1:0] retry_nx;
  logic [RW-1:0] retry_inc;
  logic          mot_expired;
  logic [1:0]    motor;
  logic          alarm;
  logic          busy;

  // Two-flop synchroniser for all asynchronous sensor inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {bus.sense, bus.obs, bus.lim_open, bus.lim_closed, bus.fault_clr};
      sync2 <= sync1;
    end
  end

  assign {s_sense, s_obs, s_lim_open, s_lim_closed, s_fault_clr} = sync2;

  // Free-running tick divider; tick_led toggles once per tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
      tick_led <= 1'b0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      tick_led <= tick_led ^ tick;
    end
  end

  assign tick = (tick_cnt == TW'(TICK_DIV - 1));

`ifdef DOOR_WATCHDOG_EN
  localparam int MW = $clog2(MOTION_TIMEOUT + 2);
  logic [MW-1:0] mot_cnt;

  // Motion watchdog: restarts on every state change, counts ticks while the motor runs, holds at the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mot_cnt <= '0;
    end else if (nxt != cur) begin
      mot_cnt <= '0;
    end else if (tick && (cur == S_OPENING || cur == S_CLOSING) && !mot_expired) begin
      mot_cnt <= mot_cnt + 1'b1;
    end
  end

  assign mot_expired = (mot_cnt == MW'(MOTION_TIMEOUT));
`else
  assign mot_expired = 1'b0;
`endif

  // Retry count saturates at the limit so it can never wrap back below it.
  assign retry_inc = (retry_cnt == RW'(MAX_RETRIES)) ? retry_cnt : retry_cnt + 1'b1;

  // Next-state and counter logic; both limit switches high is a sensor fault and overrides everything.
  always_comb begin
    nxt      = cur;
    hold_nx  = hold_cnt;
    retry_nx = retry_cnt;
    case (cur)
      S_CLOSED: begin
        if (s_sense || s_obs) nxt = S_OPENING;
      end
      S_OPENING: begin
        if (s_lim_open) begin
          nxt     = S_OPEN;
          hold_nx = HW'(HOLD_TICKS);
        end else if (mot_expired) begin
          nxt = S_FAULT;
        end
      end
      S_OPEN: begin
        // Presence reload beats a coincident tick, so the hold never shortens while someone is there.
        if (s_sense || s_obs) hold_nx = HW'(HOLD_TICKS);
        else if (hold_cnt == '0) nxt = S_CLOSING;
        else if (tick) hold_nx = hold_cnt - 1'b1;
      end
      S_CLOSING: begin
        // Obstacle beats the closed limit: a late obstacle still reverses and counts.
        if (s_obs) begin
          retry_nx = retry_inc;
          nxt      = (retry_inc >= RW'(MAX_RETRIES)) ? S_FAULT : S_OPENING;
        end else if (s_lim_closed) begin
          nxt      = S_CLOSED;
          retry_nx = '0;
        end else if (s_sense) begin
          nxt = S_OPENING;
        end else if (mot_expired) begin
          nxt = S_FAULT;
        end
      end
      S_FAULT: begin
        if (s_fault_clr) begin
          nxt      = S_OPENING;
          retry_nx = '0;
        end
      end
      default: nxt = S_FAULT;
    endcase
    if (cur != S_FAULT && s_lim_open && s_lim_closed) nxt = S_FAULT;
  end

  // State register with outputs registered from the next state, so they always match the state code.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur       <= S_CLOSED;
      hold_cnt  <= '0;
      retry_cnt <= '0;
      motor     <= 2'b00;
      alarm     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      cur       <= nxt;
      hold_cnt  <= hold_nx;
      retry_cnt <= retry_nx;
      motor     <= (nxt == S_OPENING) ? 2'b01 : (nxt == S_CLOSING) ? 2'b10 : 2'b00;
      alarm     <= (nxt == S_FAULT);
      busy      <= (nxt == S_OPENING) || (nxt == S_CLOSING);
    end
  end

  assign bus.motor    = motor;
  assign bus.alarm    = alarm;
  assign bus.busy     = busy;
  assign bus.state    = cur;
  assign bus.tick_led = tick_led;

endmodule

// File: tb/tb_door_motion_sequencer.sv
// Directed bench for door_motion_sequencer: vector table for the main sequences plus hand-written
// sequences for reset, tick timing, input latency, async reset mid-motion and the motion watchdog.
module tb_door_motion_sequencer;
  localparam int TICK_DIV       = 4;
  localparam int HOLD_TICKS     = 2;
  localparam int MAX_RETRIES    = 2;
  localparam int MOTION_TIMEOUT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  door_motion_sequencer_if bus ();

  door_motion_sequencer #(
    .TICK_DIV      (TICK_DIV),
    .HOLD_TICKS    (HOLD_TICKS),
    .MAX_RETRIES   (MAX_RETRIES),
    .MOTION_TIMEOUT(MOTION_TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic sense;
    logic obs;
    logic lo;
    logic lc;
    logic fclr;
    int   cycles;
    int   st;
    int   mot;
    int   al;
    int   bz;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic s, input logic o, input logic lo, input logic lc, input logic fc,
                     input int cyc, input int st, input int mot, input int al, input int bz);
    vec_t v;
    v.sense = s; v.obs = o; v.lo = lo; v.lc = lc; v.fclr = fc;
    v.cycles = cyc; v.st = st; v.mot = mot; v.al = al; v.bz = bz;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic s, input logic o, input logic lo, input logic lc, input logic fc);
    @(negedge clk);
    bus.sense = s; bus.obs = o; bus.lim_open = lo; bus.lim_closed = lc; bus.fault_clr = fc;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input int st, input int mot, input int al, input int bz);
    check({tag, " state"}, int'(bus.state), st);
    check({tag, " motor"}, int'(bus.motor), mot);
    check({tag, " alarm"}, int'(bus.alarm), al);
    check({tag, " busy"},  int'(bus.busy),  bz);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, expected finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    logic prev;
    int   k;

    //   sense obs lo lc fclr cyc  st mot al bz
    add(0, 0, 1, 0, 0,  3,  2, 0, 0, 0);  // reach OPEN
    add(0, 0, 1, 0, 0,  5,  2, 0, 0, 0);  // hold not yet expired
    add(0, 0, 0, 0, 0,  4,  3, 2, 0, 1);  // 2 ticks elapsed -> CLOSING
    add(0, 0, 0, 1, 0,  3,  0, 0, 0, 0);  // closed limit -> CLOSED
    add(1, 0, 0, 0, 0,  3,  1, 1, 0, 1);  // retry test: reopen
    add(0, 0, 1, 0, 0,  3,  2, 0, 0, 0);
    add(0, 0, 1, 0, 0,  5,  2, 0, 0, 0);
    add(0, 0, 0, 0, 0,  4,  3, 2, 0, 1);
    add(0, 1, 0, 0, 0,  1,  3, 2, 0, 1);  // obstacle pulse, not yet seen
    add(0, 0, 0, 0, 0,  2,  1, 1, 0, 1);  // first reversal
    add(0, 0, 1, 0, 0,  3,  2, 0, 0, 0);
    add(0, 0, 1, 0, 0,  5,  2, 0, 0, 0);
    add(0, 0, 0, 0, 0,  4,  3, 2, 0, 1);
    add(0, 1, 0, 0, 0,  1,  3, 2, 0, 1);
    add(0, 0, 0, 0, 0,  2,  4, 0, 1, 0);  // second reversal -> FAULT
    add(0, 0, 0, 0, 1,  3,  1, 1, 0, 1);  // fault_clr -> OPENING
    add(0, 0, 1, 0, 0,  3,  2, 0, 0, 0);
    add(1, 0, 1, 0, 0, 40,  2, 0, 0, 0);  // presence holds door open
    add(0, 0, 1, 0, 0,  5,  2, 0, 0, 0);  // hold restarts on release
    add(0, 0, 0, 0, 0,  6,  3, 2, 0, 1);  // closes 2 ticks after release
    add(0, 0, 0, 1, 0,  3,  0, 0, 0, 0);
    add(0, 0, 1, 1, 0,  2,  0, 0, 0, 0);  // both limits: not yet seen
    add(0, 0, 1, 1, 0,  1,  4, 0, 1, 0);  // sensor fault 3 clk later
    add(0, 0, 1, 1, 1,  3,  1, 1, 0, 1);  // clear while both still high
    add(0, 0, 1, 1, 1,  1,  4, 0, 1, 0);  // FAULT re-entered next cycle
    add(0, 0, 0, 1, 0,  4,  4, 0, 1, 0);  // stays latched once clear drops
    add(0, 0, 0, 1, 1,  3,  1, 1, 0, 1);  // clean clear
    add(0, 0, 1, 0, 0,  3,  2, 0, 0, 0);
    add(0, 0, 1, 0, 0,  5,  2, 0, 0, 0);
    add(0, 0, 0, 0, 0,  4,  3, 2, 0, 1);  // motor=10 for the reset test

    bus.sense = 0; bus.obs = 0; bus.lim_open = 0; bus.lim_closed = 0; bus.fault_clr = 0;

    // Reset state
    step(3);
    check_all("reset", 0, 0, 0, 0);
    check("reset tick_led", int'(bus.tick_led), 0);
    @(negedge clk);
    rst = 1'b0;

    // tick_led period
    prev = bus.tick_led;
    k = 1;
    while (k <= 10) begin
      step(1);
      if (bus.tick_led != prev) break;
      k++;
    end
    check("first tick_led toggle clk", k, 4);
    prev = bus.tick_led;
    k = 1;
    while (k <= 10) begin
      step(1);
      if (bus.tick_led != prev) break;
      k++;
    end
    check("tick_led period clk", k, 4);

    // Input-to-motor latency: sense high for 1 clk in CLOSED
    drive(1, 0, 0, 0, 0);
    step(1);
    drive(0, 0, 0, 0, 0);
    step(1);
    check("latency 2clk motor", int'(bus.motor), 0);
    step(1);
    check_all("latency 3clk", 1, 1, 0, 1);

    foreach (vecs[i]) begin
      drive(vecs[i].sense, vecs[i].obs, vecs[i].lo, vecs[i].lc, vecs[i].fclr);
      step(vecs[i].cycles);
      check_all($sformatf("row%0d", i), vecs[i].st, vecs[i].mot, vecs[i].al, vecs[i].bz);
    end

    // Asynchronous reset while closing stops the motor before any clock edge
    check("pre-rst motor", int'(bus.motor), 2);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_all("async rst", 0, 0, 0, 0);
    step(2);
    drive(0, 0, 0, 0, 0);
    rst = 1'b0;
    step(2);
    check_all("after rst", 0, 0, 0, 0);

    // Motion timeout while OPENING with no open limit
    drive(1, 0, 0, 0, 0);
    step(1);
    drive(0, 0, 0, 0, 0);
    step(2);
    check_all("wd opening", 1, 1, 0, 1);
`ifdef DOOR_WATCHDOG_EN
    step(8);
    check("wd not early state", int'(bus.state), 1);
    step(5);
    check_all("wd expired", 4, 0, 1, 0);
`else
    step(13);
    check_all("no wd waits", 1, 1, 0, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
